branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  Multi-cycle branch/jump execution sequencer for the non-pipelined microprogrammed core.
//  Initiator side of the branch-resolution interface:
//   - decodes B-type/JAL/JALR;
//   - drives ALU compare op, branchSignal and branch_type to the branch resolver;
//   - samples the resolver's take decision;
//   - issues the PC update and the link (rd) write.
//  Started by the microsequencer; returns a done pulse.
// PARAMETERS
//  XLEN      32  datapath/PC width
//  ALU_OP_W  4   ALU opcode width (codes from core_pkg)
// PORTS
//  clk           in   1         core clock; all state on posedge
//  reset         in   1         asynchronous, active-high
//  start         in   1         1-cycle request from microsequencer; ignored while busy=1
//  opcode        in   7         instr[6:0]; sampled with start
//  funct3        in   3         instr[14:12]; sampled with start
//  pc            in   XLEN      PC of current instruction; sampled with start
//  imm           in   XLEN      sign-extended B/J/I immediate; sampled with start
//  alu_result    in   XLEN      ALU output (rs1 op rs2, or rs1+imm for JALR)
//  take_branch   in   1         resolver output, combinational from branchSignal/branch_type/flags
//  alu_op        out  ALU_OP_W  ALU operation request
//  alu_src_imm   out  1         1 = ALU B operand is imm (JALR only)
//  branchSignal  out  1         to resolver; high only in COMPARE for B-type
//  branch_type   out  2         00 EQ, 01 NE, 10 LT, 11 GE
//  pc_next       out  XLEN      new PC; valid when pc_write=1
//  pc_write      out  1         1-cycle PC load strobe
//  rd_write      out  1         1-cycle link write strobe (JAL/JALR)
//  link_data     out  XLEN      pc+4; valid when rd_write=1
//  busy          out  1         high from cycle after start until done cycle inclusive
//  done          out  1         1-cycle completion pulse
//  illegal       out  1         1-cycle with done: unsupported opcode/funct3
//  misaligned    out  1         1-cycle with done: taken target[1:0] != 00
// BEHAVIOUR
//  Reset: state=IDLE; every output 0 (branch_type=00, pc_next=0, link_data=0).
//    Asserted mid-operation: abort immediately; no pc_write/rd_write/done issued afterwards.
//  FSM: IDLE -> DECODE -> COMPARE -> UPDATE -> IDLE. start at edge E0 => done in cycle E3 (3-cycle latency).
//  IDLE:
//    - on start: latch opcode/funct3/pc/imm; go to DECODE.
//  DECODE:
//    - classify the instruction.
//    - B-type (1100011) funct3 map:
//        000 BEQ  -> SUB,  type 00
//        001 BNE  -> SUB,  type 01
//        100 BLT  -> SLT,  type 10
//        101 BGE  -> SLT,  type 11
//        110 BLTU -> SLTU, type 10
//        111 BGEU -> SLTU, type 11
//    - funct3 010/011, JALR funct3 != 000, or any other opcode: illegal.
//      Go directly to IDLE with done=illegal=1 in that cycle; no pc_write.
//  COMPARE:
//    - B-type: alu_op = mapped op; branchSignal=1; branch_type = mapped type.
//      Register take_branch at end of cycle.
//    - JAL (1101111): alu_op=ADD; branchSignal=0; target = pc+imm.
//    - JALR (1100111): alu_op=ADD; alu_src_imm=1; target = alu_result & ~1.
//  UPDATE:
//    - done=1.
//    - B-type: pc_next = taken ? pc+imm : pc+4.
//    - Jumps: pc_next = target; rd_write=1; link_data = pc+4.
//    - If pc_next[1:0] != 00 (taken branch or jump): misaligned=1; pc_write=0; rd_write=0.
//      Otherwise pc_write=1.
//    - Not-taken branches never flag misaligned.
//  Arithmetic: all adds are XLEN-bit modulo 2^XLEN.
//    Wrap-around allowed: pc=FFFF_FFFC, +4 -> 0000_0000.
//  start in any non-IDLE state: ignored, no queuing.
//  start coincident with done: ignored; accepted the following cycle.
//  Outputs not listed for a state are 0 in that state.
// STRUCTURE
//  core_pkg:
//    - ALU opcode constants (ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU).
//    - typedef br_type_e {BR_EQ, BR_NE, BR_LT, BR_GE}.
//    - opcode constants (OP_BRANCH, OP_JAL, OP_JALR).
//    - typedef bseq_state_e.
//  Sub-module branch_decode: combinational opcode/funct3 -> {alu_op, br_type, is_jump, is_jalr, illegal}.
//  The FSM and PC arithmetic stay in branch_sequencer.
//  The resolver itself sits outside; take_branch is a port.
// TESTING
//  1. BEQ pc=0x100 imm=0x20, take_branch=1 in COMPARE
//     -> branchSignal=1, type 00, alu_op SUB in COMPARE;
//        cycle E3: pc_write=1, pc_next=0x120, done=1.
//  2. BGEU pc=0x200 imm=-8, take_branch=0
//     -> alu_op SLTU, type 11; pc_next=0x204, pc_write=1, rd_write=0.
//  3. JALR pc=0x40, alu_result=0x1001
//     -> alu_src_imm=1 in COMPARE; pc_next=0x1000, rd_write=1, link_data=0x44.
//  4. JAL pc=0x10 imm=0x6 -> misaligned=1, done=1, pc_write=0, rd_write=0.
//  5. B-type funct3=010 -> done=illegal=1 in cycle E2, no pc_write, busy low from E3;
//     also pc=0xFFFF_FFFC not-taken -> pc_next=0.
//  6. Second start pulse mid-operation -> ignored.
//     reset asserted in COMPARE -> outputs 0 immediately, no done;
//     start after reset release completes normally.

Source files
------------

// File: rtl/branch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// branch_sequencer_pkg
// Shared definitions for the branch/jump sequencer:
//   - datapath and ALU opcode widths
//   - ALU opcode constants requested from the core ALU
//   - branch comparison types understood by the external resolver
//   - RV32 opcode constants for B-type, JAL and JALR
//   - sequencer FSM state encoding
//   - alignment helper for computed PC targets
// No ports (package).
// ---------------------------------------------------------------------------
package branch_sequencer_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 4;

  // ALU operation codes; ADD is deliberately non-zero so an idle bus (all 0)
  // is distinguishable from an ADD request.
  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'h1;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'h2;
  localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'h3;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'h4;

  typedef enum logic [1:0] {
    BR_EQ = 2'b00,
    BR_NE = 2'b01,
    BR_LT = 2'b10,
    BR_GE = 2'b11
  } br_type_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_DECODE  = 2'b01,
    S_COMPARE = 2'b10,
    S_UPDATE  = 2'b11
  } bseq_state_e;

  // A PC target is only legal on a 4-byte boundary.
  function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/branch_sequencer_if.sv
// ---------------------------------------------------------------------------
// branch_sequencer_if
// Bundles the microsequencer request, the ALU/resolver handshake and the
// PC/link update outputs of the branch sequencer.
//   master : the branch sequencer (drives ALU request, resolver controls,
//            PC/link strobes and status)
//   slave  : the surrounding core (drives start, instruction fields, ALU
//            result and the resolver's take decision)
// ---------------------------------------------------------------------------
interface branch_sequencer_if;
  import branch_sequencer_pkg::*;

  // request from microsequencer
  logic                start;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [XLEN-1:0]     pc;
  logic [XLEN-1:0]     imm;
  // ALU / resolver feedback
  logic [XLEN-1:0]     alu_result;
  logic                take_branch;
  // ALU / resolver controls
  logic [ALU_OP_W-1:0] alu_op;
  logic                alu_src_imm;
  logic                branchSignal;
  logic [1:0]          branch_type;
  // PC / link update
  logic [XLEN-1:0]     pc_next;
  logic                pc_write;
  logic                rd_write;
  logic [XLEN-1:0]     link_data;
  // status
  logic                busy;
  logic                done;
  logic                illegal;
  logic                misaligned;

  modport master (
    input  start, opcode, funct3, pc, imm, alu_result, take_branch,
    output alu_op, alu_src_imm, branchSignal, branch_type,
           pc_next, pc_write, rd_write, link_data,
           busy, done, illegal, misaligned
  );

  modport slave (
    output start, opcode, funct3, pc, imm, alu_result, take_branch,
    input  alu_op, alu_src_imm, branchSignal, branch_type,
           pc_next, pc_write, rd_write, link_data,
           busy, done, illegal, misaligned
  );

endinterface

// File: rtl/branch_sequencer_decode.sv
// ---------------------------------------------------------------------------
// branch_sequencer_decode
// Combinational classification of a latched instruction.
//   i_opcode  : instr[6:0]
//   i_funct3  : instr[14:12]
//   o_alu_op  : ALU operation to request in COMPARE
//   o_br_type : comparison type for the resolver (B-type only)
//   o_is_jump : JAL or JALR
//   o_is_jalr : JALR (ALU B operand = imm, target from ALU)
//   o_illegal : unsupported opcode/funct3 combination
// ---------------------------------------------------------------------------
module branch_sequencer_decode
  import branch_sequencer_pkg::*;
(
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_funct3,
  output logic [ALU_OP_W-1:0] o_alu_op,
  output br_type_e            o_br_type,
  output logic                o_is_jump,
  output logic                o_is_jalr,
  output logic                o_illegal
);

  // opcode/funct3 -> ALU op, comparison type and instruction class
  always_comb begin
    o_alu_op  = ALU_ADD;
    o_br_type = BR_EQ;
    o_is_jump = 1'b0;
    o_is_jalr = 1'b0;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_BRANCH: begin
        case (i_funct3)
          3'b000:  begin o_alu_op = ALU_SUB;  o_br_type = BR_EQ; end
          3'b001:  begin o_alu_op = ALU_SUB;  o_br_type = BR_NE; end
          3'b100:  begin o_alu_op = ALU_SLT;  o_br_type = BR_LT; end
          3'b101:  begin o_alu_op = ALU_SLT;  o_br_type = BR_GE; end
          3'b110:  begin o_alu_op = ALU_SLTU; o_br_type = BR_LT; end
          3'b111:  begin o_alu_op = ALU_SLTU; o_br_type = BR_GE; end
          default: o_illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        o_is_jump = 1'b1;
      end
      OP_JALR: begin
        if (i_funct3 == 3'b000) begin
          o_is_jump = 1'b1;
          o_is_jalr = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// ---------------------------------------------------------------------------
// branch_sequencer
// Multi-cycle branch/jump sequencer: IDLE -> DECODE -> COMPARE -> UPDATE.
// Ports:
//   clk   : core clock, all state on posedge
//   reset : asynchronous, active-high; aborts any operation in flight
//   bus   : branch_sequencer_if.master (request, ALU/resolver handshake,
//           PC/link update, busy/done/illegal/misaligned status)
// All outputs are registered: each output register is loaded with the value
// belonging to the state being entered, so it is visible during that state.
// Timing (start sampled at edge E0): DECODE in E1, COMPARE in E2, done in E3;
// an illegal instruction reports done/illegal in E2 with busy low from E3.
// ---------------------------------------------------------------------------
module branch_sequencer
  import branch_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  branch_sequencer_if.master   bus
);

  localparam logic [XLEN-1:0] PC_STEP   = {{(XLEN-3){1'b0}}, 3'b100};
  localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  bseq_state_e         r_state;
  bseq_state_e         w_state_nxt;

  logic [6:0]          r_opcode;
  logic [2:0]          r_funct3;
  logic [XLEN-1:0]     r_pc;
  logic [XLEN-1:0]     r_imm;

  logic [ALU_OP_W-1:0] r_alu_op,        w_alu_op;
  logic                r_alu_src_imm,   w_alu_src_imm;
  logic                r_branch_signal, w_branch_signal;
  br_type_e            r_branch_type,   w_branch_type;
  logic [XLEN-1:0]     r_pc_next,       w_pc_next;
  logic                r_pc_write,      w_pc_write;
  logic                r_rd_write,      w_rd_write;
  logic [XLEN-1:0]     r_link_data,     w_link_data;
  logic                r_busy,          w_busy;
  logic                r_done,          w_done;
  logic                r_illegal,       w_illegal;
  logic                r_misaligned,    w_misaligned;

  logic [ALU_OP_W-1:0] w_dec_alu_op;
  br_type_e            w_dec_br_type;
  logic                w_dec_is_jump;
  logic                w_dec_is_jalr;
  logic                w_dec_illegal;

  logic [XLEN-1:0]     w_pc_plus_imm;
  logic [XLEN-1:0]     w_pc_plus4;
  logic [XLEN-1:0]     w_target;
  logic                w_redirect;
  logic                w_accept;

  branch_sequencer_decode u_decode (
    .i_opcode  (r_opcode),
    .i_funct3  (r_funct3),
    .o_alu_op  (w_dec_alu_op),
    .o_br_type (w_dec_br_type),
    .o_is_jump (w_dec_is_jump),
    .o_is_jalr (w_dec_is_jalr),
    .o_illegal (w_dec_illegal)
  );

  // Modulo-2^XLEN address arithmetic; wrap-around is intentional.
  assign w_pc_plus_imm = r_pc + r_imm;
  assign w_pc_plus4    = r_pc + PC_STEP;
  // busy still high in the cycle of an illegal done, so start is refused there.
  assign w_accept      = (r_state == S_IDLE) && bus.start && !r_busy;

  // Next-state and next-output computation
  always_comb begin
    w_state_nxt     = r_state;
    w_alu_op        = '0;
    w_alu_src_imm   = 1'b0;
    w_branch_signal = 1'b0;
    w_branch_type   = BR_EQ;
    w_pc_next       = '0;
    w_pc_write      = 1'b0;
    w_rd_write      = 1'b0;
    w_link_data     = '0;
    w_done          = 1'b0;
    w_illegal       = 1'b0;
    w_misaligned    = 1'b0;
    w_target        = '0;
    w_redirect      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DECODE: begin
        if (w_dec_illegal) begin
          w_state_nxt = S_IDLE;
          w_done      = 1'b1;
          w_illegal   = 1'b1;
        end else begin
          // load the COMPARE-state request
          w_state_nxt     = S_COMPARE;
          w_alu_op        = w_dec_alu_op;
          w_alu_src_imm   = w_dec_is_jalr;
          w_branch_signal = !w_dec_is_jump;
          w_branch_type   = w_dec_is_jump ? BR_EQ : w_dec_br_type;
        end
      end
      S_COMPARE: begin
        // take_branch and alu_result are valid now; capture UPDATE results.
        w_state_nxt = S_UPDATE;
        w_done      = 1'b1;
        w_redirect  = w_dec_is_jump || bus.take_branch;
        if (w_dec_is_jalr) begin
          w_target = bus.alu_result & JALR_MASK;
        end else if (w_redirect) begin
          w_target = w_pc_plus_imm;
        end else begin
          w_target = w_pc_plus4;
        end
        w_pc_next = w_target;
        if (w_redirect && addr_misaligned(w_target)) begin
          w_misaligned = 1'b1;
        end else begin
          w_pc_write  = 1'b1;
          w_rd_write  = w_dec_is_jump;
          w_link_data = w_dec_is_jump ? w_pc_plus4 : '0;
        end
      end
      S_UPDATE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    w_busy = (w_state_nxt != S_IDLE) || w_done;
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_alu_op        <= '0;
      r_alu_src_imm   <= 1'b0;
      r_branch_signal <= 1'b0;
      r_branch_type   <= BR_EQ;
      r_pc_next       <= '0;
      r_pc_write      <= 1'b0;
      r_rd_write      <= 1'b0;
      r_link_data     <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_illegal       <= 1'b0;
      r_misaligned    <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_alu_op        <= w_alu_op;
      r_alu_src_imm   <= w_alu_src_imm;
      r_branch_signal <= w_branch_signal;
      r_branch_type   <= w_branch_type;
      r_pc_next       <= w_pc_next;
      r_pc_write      <= w_pc_write;
      r_rd_write      <= w_rd_write;
      r_link_data     <= w_link_data;
      r_busy          <= w_busy;
      r_done          <= w_done;
      r_illegal       <= w_illegal;
      r_misaligned    <= w_misaligned;
    end
  end

  // Instruction fields captured when a request is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_opcode <= '0;
      r_funct3 <= '0;
      r_pc     <= '0;
      r_imm    <= '0;
    end else if (w_accept) begin
      r_opcode <= bus.opcode;
      r_funct3 <= bus.funct3;
      r_pc     <= bus.pc;
      r_imm    <= bus.imm;
    end
  end

  assign bus.alu_op       = r_alu_op;
  assign bus.alu_src_imm  = r_alu_src_imm;
  assign bus.branchSignal = r_branch_signal;
  assign bus.branch_type  = r_branch_type;
  assign bus.pc_next      = r_pc_next;
  assign bus.pc_write     = r_pc_write;
  assign bus.rd_write     = r_rd_write;
  assign bus.link_data    = r_link_data;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.illegal      = r_illegal;
  assign bus.misaligned   = r_misaligned;

endmodule

// File: tb/tb_branch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_sequencer
// Directed test of branch_sequencer with hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  branch_sequencer_if bus ();

  branch_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive a request for one cycle; returns in cycle E1 (DECODE)
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.pc     = pc;
    bus.imm    = imm;
    tick();
    bus.start  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus.start = 1'b0; bus.opcode = 7'd0; bus.funct3 = 3'd0;
    bus.pc = 32'd0; bus.imm = 32'd0; bus.alu_result = 32'd0; bus.take_branch = 1'b0;
    tick(); tick();
    check("rst_busy",    32'(bus.busy),        32'd0);
    check("rst_done",    32'(bus.done),        32'd0);
    check("rst_pc_next", bus.pc_next,          32'd0);
    check("rst_link",    bus.link_data,        32'd0);
    check("rst_ctrl",    32'({bus.alu_op, bus.branch_type, bus.branchSignal, bus.pc_write,
                              bus.rd_write, bus.illegal, bus.misaligned, bus.alu_src_imm}), 32'd0);
    reset = 1'b0;
    tick();

    // 1: BEQ taken
    issue(OP_BRANCH, 3'b000, 32'h0000_0100, 32'h0000_0020);
    check("t1_e1_busy", 32'(bus.busy), 32'd1);
    check("t1_e1_done", 32'(bus.done), 32'd0);
    bus.take_branch = 1'b1;
    tick();
    check("t1_alu_op", 32'(bus.alu_op),       32'h2);
    check("t1_bsig",   32'(bus.branchSignal), 32'd1);
    check("t1_btype",  32'(bus.branch_type),  32'd0);
    tick();
    bus.take_branch = 1'b0;
    check("t1_done",    32'(bus.done),     32'd1);
    check("t1_pcw",     32'(bus.pc_write), 32'd1);
    check("t1_pc_next", bus.pc_next,       32'h0000_0120);
    check("t1_rdw",     32'(bus.rd_write), 32'd0);
    tick();
    check("t1_e4_busy", 32'(bus.busy), 32'd0);
    check("t1_e4_pcw",  32'(bus.pc_write), 32'd0);

    // 2: BGEU not taken, negative imm
    issue(OP_BRANCH, 3'b111, 32'h0000_0200, 32'hFFFF_FFF8);
    tick();
    check("t2_alu_op", 32'(bus.alu_op),      32'h4);
    check("t2_btype",  32'(bus.branch_type), 32'd3);
    tick();
    check("t2_pc_next", bus.pc_next,       32'h0000_0204);
    check("t2_pcw",     32'(bus.pc_write), 32'd1);
    check("t2_rdw",     32'(bus.rd_write), 32'd0);
    check("t2_mis",     32'(bus.misaligned), 32'd0);
    tick();

    // 3: JALR, low target bit cleared
    issue(OP_JALR, 3'b000, 32'h0000_0040, 32'h0000_0FC1);
    tick();
    bus.alu_result = 32'h0000_1001;
    check("t3_srcimm", 32'(bus.alu_src_imm),  32'd1);
    check("t3_alu_op", 32'(bus.alu_op),       32'h1);
    check("t3_bsig",   32'(bus.branchSignal), 32'd0);
    tick();
    bus.alu_result = 32'd0;
    check("t3_pc_next", bus.pc_next,       32'h0000_1000);
    check("t3_pcw",     32'(bus.pc_write), 32'd1);
    check("t3_rdw",     32'(bus.rd_write), 32'd1);
    check("t3_link",    bus.link_data,     32'h0000_0044);
    check("t3_done",    32'(bus.done),     32'd1);
    tick();

    // 4: JAL to misaligned target
    issue(OP_JAL, 3'b000, 32'h0000_0010, 32'h0000_0006);
    tick();
    tick();
    check("t4_mis",  32'(bus.misaligned), 32'd1);
    check("t4_done", 32'(bus.done),       32'd1);
    check("t4_pcw",  32'(bus.pc_write),   32'd0);
    check("t4_rdw",  32'(bus.rd_write),   32'd0);
    tick();
    check("t4_e4_mis", 32'(bus.misaligned), 32'd0);

    // 5a: illegal B-type funct3, start coincident with illegal done
    issue(OP_BRANCH, 3'b010, 32'h0000_0300, 32'h0000_0010);
    check("t5_e1_done", 32'(bus.done), 32'd0);
    tick();
    check("t5_done",    32'(bus.done),     32'd1);
    check("t5_illegal", 32'(bus.illegal),  32'd1);
    check("t5_pcw",     32'(bus.pc_write), 32'd0);
    check("t5_busy",    32'(bus.busy),     32'd1);
    bus.start = 1'b1; bus.opcode = OP_JAL; bus.funct3 = 3'b000;
    tick();
    bus.start = 1'b0;
    check("t5_e3_busy", 32'(bus.busy),    32'd0);
    check("t5_e3_ill",  32'(bus.illegal), 32'd0);
    tick();
    check("t5_ign_busy", 32'(bus.busy), 32'd0);

    // 5b: illegal JALR funct3
    issue(OP_JALR, 3'b001, 32'h0000_0300, 32'h0000_0000);
    tick();
    check("t5b_illegal", 32'(bus.illegal), 32'd1);
    tick();

    // 5c: PC wrap on not-taken branch
    issue(OP_BRANCH, 3'b000, 32'hFFFF_FFFC, 32'h0000_0010);
    tick();
    tick();
    check("t5c_pc_next", bus.pc_next,       32'h0000_0000);
    check("t5c_pcw",     32'(bus.pc_write), 32'd1);
    check("t5c_mis",     32'(bus.misaligned), 32'd0);
    tick();

    // 6a: start mid-operation ignored; start with done ignored, next cycle accepted
    issue(OP_BRANCH, 3'b001, 32'h0000_0300, 32'h0000_0040);
    bus.start = 1'b1; bus.opcode = OP_JAL; bus.pc = 32'h0000_0999; bus.imm = 32'h0000_0004;
    bus.take_branch = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t6_alu_op", 32'(bus.alu_op),      32'h2);
    check("t6_btype",  32'(bus.branch_type), 32'd1);
    check("t6_bsig",   32'(bus.branchSignal), 32'd1);
    tick();
    check("t6_pc_next", bus.pc_next,       32'h0000_0340);
    check("t6_rdw",     32'(bus.rd_write), 32'd0);
    bus.start = 1'b1; bus.opcode = OP_BRANCH; bus.funct3 = 3'b000;
    bus.pc = 32'h0000_0500; bus.imm = 32'h0000_0008;
    tick();
    check("t6_coinc_busy", 32'(bus.busy), 32'd0);
    tick();
    bus.start = 1'b0;
    check("t6_acc_busy", 32'(bus.busy), 32'd1);
    tick();
    check("t6_acc_bsig", 32'(bus.branchSignal), 32'd1);
    tick();
    bus.take_branch = 1'b0;
    check("t6_acc_pc_next", bus.pc_next,       32'h0000_0508);
    check("t6_acc_done",    32'(bus.done),     32'd1);
    tick();

    // 6b: reset during COMPARE aborts
    issue(OP_JAL, 3'b000, 32'h0000_0080, 32'h0000_0100);
    tick();
    check("t6r_alu_op", 32'(bus.alu_op), 32'h1);
    reset = 1'b1;
    #1;
    check("t6r_alu_zero",  32'(bus.alu_op), 32'd0);
    check("t6r_busy_zero", 32'(bus.busy),   32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("t6r_no_done", 32'(bus.done),     32'd0);
    check("t6r_no_pcw",  32'(bus.pc_write), 32'd0);
    tick();
    check("t6r_no_rdw",  32'(bus.rd_write), 32'd0);
    issue(OP_JAL, 3'b000, 32'h0000_0080, 32'h0000_0100);
    tick();
    tick();
    check("t6r_pc_next", bus.pc_next,       32'h0000_0180);
    check("t6r_rdw",     32'(bus.rd_write), 32'd1);
    check("t6r_link",    bus.link_data,     32'h0000_0084);
    check("t6r_done",    32'(bus.done),     32'd1);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
